sleep_scheduler: RTL
====================

# sleep_scheduler

Upstream feeder for the clock-wait stage. Accepts timed-sleep commands (16-bit value, 5-bit divider) from the control unit over a valid/ready handshake and buffers them in a small FIFO. It presents one command at a time as a one-cycle `sleep` load strobe with stable `value`/`divider`, and tracks the same countdown the clock-wait stage runs, so the control unit gets a `done` pulse when the sleep ends. Branch-CPU `wake` stalls the countdown; `abort` flushes everything.

## Interface
- DEPTH, 2: command FIFO entries (power of two, ≥2)
- sclk  in  1: system clock, all logic on rising edge
- reset  in  1: synchronous, active-high
- cmd_valid  in  1: control unit offers a command
- cmd_ready  out  1: command accepted on edge when valid&ready
- cmd_value  in  16: sleep length in divided ticks
- cmd_divider  in  5: tick divider; ticks are (divider+1) sclk cycles
- wake  in  1: from BranchCPU; 0 freezes LOAD/WAIT progress
- abort  in  1: flush FIFO and cancel active sleep
- sleep  out  1: one-cycle load strobe to clock-wait stage
- value  out  16: registered value for current command
- divider  out  5: registered divider for current command
- busy  out  1: state ≠ IDLE
- done  out  1: one-cycle pulse at normal completion
- aborted  out  1: one-cycle pulse when abort cancels an active command or non-empty FIFO
- level  out  $clog2(DEPTH)+1: FIFO occupancy

## Operation
- Reset: all outputs 0 except cmd_ready=1; FIFO empty; state IDLE; count 0.
- cmd_ready = !full && !abort. Push on valid&ready.
- States: IDLE, LOAD, WAIT, DONE.
- IDLE: FIFO non-empty → LOAD; latch head into value/divider on that edge.
- LOAD: sleep=1. If wake=1: count ← value*(divider+1)+1 (21-bit, max 2 097 121, no overflow), → WAIT. If wake=0: stay, sleep stays 1.
- WAIT: wake=1 and count==1 → DONE; wake=1 otherwise count−1; wake=0 hold.
- DONE: done=1, pop head on edge. More than one entry → LOAD (latch next head, no bubble); else → IDLE.
- value=0 gives count=1: one WAIT cycle.
- abort (any state): next edge FIFO empty, count 0, state IDLE, value/divider held; aborted pulses next cycle if state≠IDLE or FIFO non-empty; done suppressed. abort beats a same-cycle push (cmd_ready=0) and DONE.
- Push and pop on the same edge are legal when full; the push is not accepted because cmd_ready reflects the pre-edge full state.
- reset mid-WAIT: identical to power-on reset; no done, no aborted.

## Timing
- Cycle k = interval after edge k; command accepted at edge 0, FIFO empty, IDLE, wake=1:
  - cycle 1: LOAD, sleep=1, value/divider valid
  - cycles 2 .. C+1: WAIT, C = value*(divider+1)+1
  - cycle C+2: DONE, done=1
- Each wake=0 cycle in LOAD/WAIT adds one cycle.
- Back-to-back: next LOAD directly follows DONE.
- level updates the cycle after push/pop.

## Structure
- Shared package `sleep_pkg`: state enum (IDLE, LOAD, WAIT, DONE), COUNT_W=21, VALUE_W=16, DIV_W=5, function computing value*(divider+1)+1 at COUNT_W.
- Sub-module `sleep_cmd_fifo`: synchronous FIFO, DEPTH×21 bits, push/pop/full/empty/level, sync reset.

## Test plan
- Single command value=3, divider=1, wake=1 → sleep in cycle 1, done in cycle 9, busy cycles 1–9.
- Same command, wake low for cycles 4–6 → done moves to cycle 12; count frozen during the stall.
- value=0, divider=0 → LOAD cycle 1, one WAIT cycle 2, done cycle 3.
- Three commands pushed back-to-back with DEPTH=2 → third stalls (cmd_ready=0) until first DONE. Second LOAD immediately follows first DONE. Three done pulses in order.
- abort during WAIT with one entry queued → cycle after: busy=0, level=0, aborted=1, done never pulses. A same-cycle cmd_valid is not accepted.
- reset asserted mid-WAIT (value=0xFFFF, divider=31) → next cycle all outputs at reset values, cmd_ready=1, no done/aborted.

Source files
------------

// File: rtl/sleep_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sleep_pkg
// Shared definitions for the sleep scheduler: field widths, the command record
// stored in the FIFO, the scheduler state encoding and the countdown length
// helper. The countdown length must match the one the downstream clock-wait
// stage runs, so it lives here in one place.
// -----------------------------------------------------------------------------
package sleep_pkg;

    localparam int VALUE_W = 16;
    localparam int DIV_W   = 5;
    localparam int COUNT_W = 21;
    localparam int CMD_W   = VALUE_W + DIV_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } sleep_state_e;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [DIV_W-1:0]   divider;
    } sleep_cmd_t;

    // value*(divider+1)+1. The largest result is 65535*32+1 = 2 097 121,
    // which fits in COUNT_W bits, so the truncating multiply is exact.
    function automatic logic [COUNT_W-1:0] sleep_count(
        input logic [VALUE_W-1:0] v,
        input logic [DIV_W-1:0]   d
    );
        logic [COUNT_W-1:0] ticks;
        ticks = COUNT_W'(d) + COUNT_W'(1);
        return COUNT_W'(v) * ticks + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/sleep_scheduler_if.sv
// -----------------------------------------------------------------------------
// sleep_scheduler_if
// Command handshake between the control unit and the sleep scheduler.
//   cmd_valid   : control unit offers a command
//   cmd_ready   : scheduler accepts it on the edge where valid & ready
//   cmd_value   : sleep length in divided ticks
//   cmd_divider : tick divider, one tick = divider+1 clock cycles
// Modports: master = control unit, slave = scheduler.
// -----------------------------------------------------------------------------
interface sleep_scheduler_if;
    import sleep_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [VALUE_W-1:0] cmd_value;
    logic [DIV_W-1:0]   cmd_divider;

    modport master (
        output cmd_valid,
        output cmd_value,
        output cmd_divider,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_value,
        input  cmd_divider,
        output cmd_ready
    );

endinterface

// File: rtl/sleep_cmd_fifo.sv
// -----------------------------------------------------------------------------
// sleep_cmd_fifo
// Synchronous FIFO for sleep commands with a one-entry look-ahead.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (empties the FIFO)
//   flush_i  : synchronous flush, wins over push and pop
//   push_i   : write wdata_i (ignored when full)
//   pop_i    : drop the head entry (ignored when empty)
//   wdata_i  : entry to write
//   head_o   : oldest entry
//   next_o   : entry behind the head, lets the consumer start the next
//              command on the same edge it pops the current one
//   full_o, empty_o, level_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sleep_cmd_fifo
    import sleep_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = CMD_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [WIDTH-1:0]       next_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign rd_next = rd_ptr_q + AW'(1);
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_next];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_next;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; empty_o gates every use of it.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sleep_scheduler.sv
// -----------------------------------------------------------------------------
// sleep_scheduler
// Buffers timed-sleep commands from the control unit and hands them one at a
// time to the clock-wait stage, mirroring that stage's countdown so that the
// control unit sees a done pulse when the sleep ends.
//   sclk     : clock, rising edge
//   reset    : synchronous active-high reset
//   cmd      : command handshake (slave side)
//   wake     : 0 freezes LOAD/WAIT progress
//   abort    : flush FIFO and cancel the active command
//   sleep    : one-cycle load strobe (held while wake=0 in LOAD)
//   value    : value of the current command
//   divider  : divider of the current command
//   busy     : a command is being processed
//   done     : one-cycle pulse on normal completion
//   aborted  : one-cycle pulse when abort cancelled real work
//   level    : FIFO occupancy (includes the command being processed)
// The active command stays at the FIFO head until its DONE cycle.
// -----------------------------------------------------------------------------
module sleep_scheduler
    import sleep_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   sclk,
    input  logic                   reset,
    sleep_scheduler_if.slave       cmd,
    input  logic                   wake,
    input  logic                   abort,
    output logic                   sleep,
    output logic [VALUE_W-1:0]     value,
    output logic [DIV_W-1:0]       divider,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW = $clog2(DEPTH) + 1;

    sleep_state_e       state_q;
    logic [COUNT_W-1:0] count_q;
    logic               sleep_q, busy_q, done_q, aborted_q;
    logic [VALUE_W-1:0] value_q;
    logic [DIV_W-1:0]   divider_q;

    sleep_cmd_t         push_cmd, head_cmd, next_cmd;
    logic               fifo_full, fifo_empty;
    logic [LW-1:0]      fifo_level;
    logic               push, pop;
    logic [COUNT_W-1:0] count_init;

    // abort blocks acceptance so a command offered in the abort cycle is
    // never pushed into the FIFO that is being flushed.
    assign cmd.cmd_ready = !fifo_full && !abort;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state_q == DONE) && !abort;

    assign push_cmd.value   = cmd.cmd_value;
    assign push_cmd.divider = cmd.cmd_divider;

    assign count_init = sleep_count(value_q, divider_q);

    sleep_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_i   (sclk),
        .rst_i   (reset),
        .flush_i (abort),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_cmd),
        .head_o  (head_cmd),
        .next_o  (next_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            sleep_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            value_q   <= '0;
            divider_q <= '0;
        end else if (abort) begin
            // value/divider are intentionally left holding the last command.
            state_q   <= IDLE;
            count_q   <= '0;
            sleep_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= (state_q != IDLE) || !fifo_empty;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= LOAD;
                        value_q   <= head_cmd.value;
                        divider_q <= head_cmd.divider;
                        sleep_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wake) begin
                        state_q <= WAIT;
                        count_q <= count_init;
                        sleep_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wake) begin
                        if (count_q == COUNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            count_q <= count_q - COUNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // The head is popped on this edge; a second entry goes
                    // straight to LOAD so back-to-back sleeps have no gap.
                    if (fifo_level > LW'(1)) begin
                        state_q   <= LOAD;
                        value_q   <= next_cmd.value;
                        divider_q <= next_cmd.divider;
                        sleep_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sleep   = sleep_q;
    assign value   = value_q;
    assign divider = divider_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign level   = fifo_level;

endmodule
